// File: rtl/ex_mul_seq.sv
// Shift-add unsigned multiplier that borrows the shared execute ALU; done pulses WIDTH+1 cycles after an accepted start.
// A start is taken only in IDLE/DONE. While busy, stall holds the pipeline and further starts are dropped.
module ex_mul_seq #(
  parameter int         WIDTH  = 16,
  parameter int         CNT_W  = 5,
  parameter logic [3:0] ADD_OP = 4'b0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_cout,
  output logic                 alu_grab,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_op,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 accept;
  logic                 last;
  logic [2*WIDTH-1:0]   step_val;

  assign step_val = {alu_cout, alu_out, lo_q[WIDTH-1:1]};
  assign last     = (count_q == LAST_CNT);

  always_comb begin
    state_d  = IDLE;
    accept   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ITER: begin
        busy = 1'b1;
        if (flush)     state_d = IDLE;
        else if (last) state_d = DONE;
        else           state_d = ITER;
      end
      DONE: begin
        done   = 1'b1;
        accept = start & ~flush;
        state_d = accept ? ITER : IDLE;
      end
      default: begin
        // The unused 2'b11 encoding behaves exactly like IDLE.
        accept  = start & ~flush;
        state_d = accept ? ITER : IDLE;
      end
    endcase
  end

  assign stall    = busy;
  assign alu_grab = busy;
  assign alu_a    = busy ? hi_q : '0;
  assign alu_b    = (busy && lo_q[0]) ? mcand_q : '0;
  assign alu_op   = busy ? ADD_OP : 4'b0000;
  assign product  = product_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q <= op_a;
        lo_q    <= op_b;
        hi_q    <= '0;
        count_q <= '0;
      end else if (busy && !flush) begin
        {hi_q, lo_q} <= step_val;
        count_q      <= count_q + CNT_W'(1);
        // Latch the result on the final step so it stays put through IDLE.
        if (last) product_q <= step_val;
      end
    end
  end

endmodule

// File: tb/tb_ex_mul_seq.sv
// Scoreboard bench for ex_mul_seq with a behavioural model of the shared ALU.
module tb_ex_mul_seq;

  localparam int WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 flush;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH-1:0]     alu_out;
  logic                 alu_cout;
  logic                 alu_grab;
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [3:0]           alu_op;
  logic                 busy;
  logic                 stall;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_prod = 32'h0;

  always #5 clk = ~clk;

  assign {alu_cout, alu_out} = (alu_op == 4'b0100) ? ({1'b0, alu_a} + {1'b0, alu_b}) : 17'h0;

  ex_mul_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .alu_out  (alu_out),
    .alu_cout (alu_cout),
    .alu_grab (alu_grab),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .product  (product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'h0);
      end else begin
        check("product", product, sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] a, input logic [15:0] b, input bit push);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    if (push) begin
      sb_q.push_back(32'(a) * 32'(b));
      last_prod = 32'(a) * 32'(b);
    end
    step();
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check({tag, "_stall"}, {31'b0, stall}, 32'h0);
    check({tag, "_done"}, {31'b0, done}, 32'h0);
    check({tag, "_grab"}, {31'b0, alu_grab}, 32'h0);
    check({tag, "_alu_ab_op"}, {12'b0, alu_op, alu_a | alu_b}, 32'h0);
  endtask

  task automatic mul(input logic [15:0] a, input logic [15:0] b);
    do_start(a, b, 1'b1);
    for (int i = 1; i <= WIDTH; i++) begin
      check("iter_busy", {30'b0, busy, stall}, 32'h3);
      check("iter_grab", {27'b0, alu_grab, alu_op}, 32'h14);
      check("iter_no_done", {31'b0, done}, 32'h0);
      step();
    end
    check("done_pulse", {30'b0, done, busy}, 32'h2);
    step();
    check("done_one_cycle", {31'b0, done}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    check("reset_product", product, 32'h0);
    rst = 1'b0;
    step();

    // 1: basic timing and result
    mul(16'd3, 16'd5);

    // 2: extremes
    mul(16'hFFFF, 16'hFFFF);
    mul(16'h0000, 16'h1234);

    // 3: start during ITER is dropped
    do_start(16'd3000, 16'd7, 1'b1);
    repeat (4) step();
    start = 1'b1; op_a = 16'd1; op_b = 16'd1;
    step();
    start = 1'b0;
    repeat (10) step();
    check("s3_still_busy", {31'b0, busy}, 32'h1);
    step();
    check("s3_done", {31'b0, done}, 32'h1);
    step();
    check_idle_outputs("s3_no_requeue");

    // 4: flush aborts; flush also blocks start in IDLE
    do_start(16'd55, 16'd66, 1'b0);
    repeat (7) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_idle_outputs("s4_flushed");
    check("s4_product_kept", product, last_prod);
    repeat (20) step();
    check("s4_product_still", product, last_prod);
    start = 1'b1; flush = 1'b1; op_a = 16'd9; op_b = 16'd9;
    step();
    start = 1'b0; flush = 1'b0;
    check_idle_outputs("s4_start_blocked");

    // 5: back-to-back start from DONE
    do_start(16'd100, 16'd200, 1'b1);
    repeat (16) step();
    check("s5_first_done", {31'b0, done}, 32'h1);
    do_start(16'd7, 16'd9, 1'b1);
    check("s5_reiter", {31'b0, busy}, 32'h1);
    repeat (15) step();
    check("s5_last_iter", {31'b0, busy}, 32'h1);
    step();
    check("s5_second_done", {31'b0, done}, 32'h1);
    check("s5_product", product, 32'd63);
    step();

    // 6: reset mid-ITER
    do_start(16'd5, 16'd6, 1'b0);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("s6_reset");
    check("s6_product", product, 32'h0);
    step();
    mul(16'd3, 16'd5);

    // Random operands
    for (int k = 0; k < 6; k++) begin
      mul(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    end

    repeat (5) step();
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
